// File: rtl/lk_grad_accum_if.sv
// Gradient-pair input stream and windowed structure-tensor sum outputs
// of the Lucas-Kanade window accumulator.
interface lk_grad_accum_if #(
    parameter int data_width = 8,
    parameter int acc_width  = 2 * data_width + 6
);
    logic signed [data_width:0]  Ix;
    logic                        Ix_val;
    logic signed [data_width:0]  Iy;
    logic                        Iy_val;
    logic                        new_row;
    logic signed [acc_width-1:0] Sxx;
    logic signed [acc_width-1:0] Syy;
    logic signed [acc_width-1:0] Sxy;
    logic                        sum_val;
    logic                        err;

    modport master (
        output Ix, Ix_val, Iy, Iy_val, new_row,
        input  Sxx, Syy, Sxy, sum_val, err
    );

    modport slave (
        input  Ix, Ix_val, Iy, Iy_val, new_row,
        output Sxx, Syy, Sxy, sum_val, err
    );
endinterface

// File: rtl/lk_grad_accum.sv
// Sliding horizontal box sums of Ix*Ix, Iy*Iy and Ix*Iy over the last W samples
// of the current row; stage 1 registers products, stage 2 updates the window.
module lk_grad_accum #(
    parameter int data_width = 8,
    parameter int acc_width  = 2 * data_width + 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] win_dim,
    lk_grad_accum_if.slave bus
);
    localparam int pw    = 2 * data_width + 2;
    localparam int depth = 15;

    typedef struct packed {
        logic signed [pw-1:0] xx;
        logic signed [pw-1:0] yy;
        logic signed [pw-1:0] xy;
    } prod_t;

    logic accept;
    logic signed [pw-1:0] ix_ext;
    logic signed [pw-1:0] iy_ext;

    prod_t s1;
    logic  s1_val;
    logic  s1_tag;
    logic  pending;

    assign accept = bus.Ix_val && bus.Iy_val;
    assign ix_ext = pw'(bus.Ix);
    assign iy_ext = pw'(bus.Iy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= '0;
            s1_val  <= 1'b0;
            s1_tag  <= 1'b0;
            pending <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values
            s1_val <= accept;
            if (accept) begin
                s1.xx   <= ix_ext * ix_ext;
                s1.yy   <= iy_ext * iy_ext;
                s1.xy   <= ix_ext * iy_ext;
                s1_tag  <= bus.new_row | pending;
                pending <= 1'b0;
            end else if (bus.new_row) begin
                pending <= 1'b1;
            end
            if (bus.Ix_val ^ bus.Iy_val) begin
                bus.err <= 1'b1;
            end
        end
    end

    prod_t      dl [depth];
    logic [3:0] fill;
    logic [3:0] w;
    logic       w_loaded;

    logic [3:0] w_in;
    logic [3:0] w_use;
    logic [3:0] fill_base;
    logic [3:0] fill_next;
    prod_t      p_out;
    logic signed [acc_width-1:0] base_xx, base_yy, base_xy;

    // A tagged sample restarts the row: fill and sums start from zero and W reloads.
    always_comb begin
        w_in      = (win_dim == 4'd0) ? 4'd1 : win_dim;
        w_use     = s1_tag ? w_in : w;
        fill_base = s1_tag ? 4'd0 : fill;
        fill_next = (fill_base == 4'd15) ? 4'd15 : fill_base + 4'd1;
        p_out     = '0;
        if (fill_base >= w_use) begin
            p_out = dl[w_use - 4'd1];
        end
        base_xx = s1_tag ? '0 : bus.Sxx;
        base_yy = s1_tag ? '0 : bus.Syy;
        base_xy = s1_tag ? '0 : bus.Sxy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the delay line is reset explicitly so it never holds X after power-up
            for (int i = 0; i < depth; i++) begin
                dl[i] <= '0;
            end
            fill        <= 4'd0;
            w           <= 4'd1;
            w_loaded    <= 1'b0;
            bus.Sxx     <= '0;
            bus.Syy     <= '0;
            bus.Sxy     <= '0;
            bus.sum_val <= 1'b0;
        end else begin
            if (!w_loaded) begin
                w        <= w_in;
                w_loaded <= 1'b1;
            end
            bus.sum_val <= 1'b0;
            if (s1_val) begin
                if (s1_tag) begin
                    w <= w_in;
                end
                dl[0] <= s1;
                for (int i = 1; i < depth; i++) begin
                    dl[i] <= dl[i-1];
                end
                fill        <= fill_next;
                bus.Sxx     <= base_xx + acc_width'(s1.xx) - acc_width'(p_out.xx);
                bus.Syy     <= base_yy + acc_width'(s1.yy) - acc_width'(p_out.yy);
                bus.Sxy     <= base_xy + acc_width'(s1.xy) - acc_width'(p_out.xy);
                bus.sum_val <= (fill_next >= w_use);
            end
        end
    end
endmodule

// File: tb/tb_lk_grad_accum.sv
// Scoreboard bench for lk_grad_accum: a reference row model predicts every windowed
// sum with its due cycle; a negedge monitor pops and compares each sum_val.
module tb_lk_grad_accum;
    localparam int DW = 8;
    localparam int AW = 2 * DW + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] win_dim;

    lk_grad_accum_if #(.data_width(DW), .acc_width(AW)) bus ();

    lk_grad_accum #(.data_width(DW), .acc_width(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .win_dim (win_dim),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint xx;
        longint yy;
        longint xy;
        int     due;
    } exp_t;

    exp_t   sb[$];
    longint hx[$], hy[$], hxy[$];
    int     m_w;
    bit     m_pend;

    int     cyc = 0;
    int     tests_run = 0;
    int     tests_failed = 0;
    int     sv_count = 0;
    longint last_xx, last_yy, last_xy;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.sum_val === 1'b1) begin
            tests_run++;
            sv_count++;
            last_xx = longint'(bus.Sxx);
            last_yy = longint'(bus.Syy);
            last_xy = longint'(bus.Sxy);
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_sum_val cycle %0d: got Sxx=%0d Syy=%0d Sxy=%0d, none expected",
                         cyc, last_xx, last_yy, last_xy);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (cyc !== e.due || last_xx !== e.xx || last_yy !== e.yy || last_xy !== e.xy) begin
                    tests_failed++;
                    $display("FAIL sum_check: got cycle=%0d Sxx=%0d Syy=%0d Sxy=%0d, want cycle=%0d Sxx=%0d Syy=%0d Sxy=%0d",
                             cyc, last_xx, last_yy, last_xy, e.due, e.xx, e.yy, e.xy);
                end
            end
        end
    end

    task automatic model_clear();
        hx.delete();
        hy.delete();
        hxy.delete();
        sb.delete();
        m_pend = 1'b0;
        m_w = (win_dim == 4'd0) ? 1 : int'(win_dim);
    endtask

    // Drive one cycle of inputs and advance the reference model.
    task automatic step(input bit xv, input bit yv, input int ix, input int iy, input bit nr);
        bus.Ix      = (DW+1)'(ix);
        bus.Iy      = (DW+1)'(iy);
        bus.Ix_val  = xv;
        bus.Iy_val  = yv;
        bus.new_row = nr;
        if (xv && yv) begin
            if (nr || m_pend) begin
                hx.delete();
                hy.delete();
                hxy.delete();
                m_w = (win_dim == 4'd0) ? 1 : int'(win_dim);
            end
            m_pend = 1'b0;
            hx.push_back(longint'(ix) * ix);
            hy.push_back(longint'(iy) * iy);
            hxy.push_back(longint'(ix) * iy);
            if (hx.size() >= m_w) begin
                exp_t e;
                e.xx = 0; e.yy = 0; e.xy = 0;
                for (int k = hx.size() - m_w; k < hx.size(); k++) begin
                    e.xx += hx[k];
                    e.yy += hy[k];
                    e.xy += hxy[k];
                end
                e.due = cyc + 2;
                sb.push_back(e);
            end
        end else if (nr) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_drained(input string name, input int exp_count, input int start_count);
        idle(4);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: %0d expected sums never appeared, want 0", name, sb.size());
            sb.delete();
        end
        tests_run++;
        if (sv_count - start_count != exp_count) begin
            tests_failed++;
            $display("FAIL %s_count: got %0d sum_val pulses, want %0d", name, sv_count - start_count, exp_count);
        end
    endtask

    task automatic check_last(input string name, input longint xx, input longint yy, input longint xy);
        tests_run++;
        if (last_xx !== xx || last_yy !== yy || last_xy !== xy) begin
            tests_failed++;
            $display("FAIL %s_last: got Sxx=%0d Syy=%0d Sxy=%0d, want Sxx=%0d Syy=%0d Sxy=%0d",
                     name, last_xx, last_yy, last_xy, xx, yy, xy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        win_dim = 4'd3;
        bus.Ix = '0; bus.Iy = '0; bus.Ix_val = 1'b0; bus.Iy_val = 1'b0; bus.new_row = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        idle(2);
        tests_run++;
        if (bus.Sxx !== '0 || bus.Syy !== '0 || bus.Sxy !== '0) begin
            tests_failed++;
            $display("FAIL reset_sums: got %0d %0d %0d, want 0 0 0", bus.Sxx, bus.Syy, bus.Sxy);
        end
        tests_run++;
        if (bus.sum_val !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got sum_val=%b err=%b, want 0 0", bus.sum_val, bus.err);
        end
    endtask

    task automatic test_uniform();
        int c0 = sv_count;
        win_dim = 4'd3;
        idle(1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 2, -3, i == 0);
        check_drained("uniform", 3, c0);
        check_last("uniform", 12, 27, -18);
    endtask

    task automatic test_sliding();
        int c0 = sv_count;
        win_dim = 4'd2;
        idle(1);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, i, 1, i == 1);
        check_drained("sliding", 3, c0);
        check_last("sliding", 25, 2, 7);
    endtask

    task automatic test_row_restart();
        int c0 = sv_count;
        win_dim = 4'd2;
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5, 0, i == 0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1, 0, i == 0);
        check_drained("restart_tagged", 3, c0);
        check_last("restart_tagged", 2, 0, 0);
        c0 = sv_count;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5, 0, i == 0);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1, 0, 1'b0);
        check_drained("restart_pending", 3, c0);
        check_last("restart_pending", 2, 0, 0);
    endtask

    task automatic test_extremes();
        int c0 = sv_count;
        win_dim = 4'd15;
        idle(1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, -256, 255, i == 0);
        check_drained("extreme_w15", 1, c0);
        check_last("extreme_w15", 983040, 975375, -979200);
        c0 = sv_count;
        win_dim = 4'd0;
        idle(1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, $urandom_range(0, 511) - 256, $urandom_range(0, 510) - 255, i == 0);
        check_drained("w0_as_w1", 6, c0);
    endtask

    task automatic test_mismatch();
        int c0 = sv_count;
        win_dim = 4'd2;
        idle(1);
        step(1'b1, 1'b1, 3, 2, 1'b1);
        step(1'b1, 1'b0, 7, 7, 1'b0);
        step(1'b0, 1'b1, 7, 7, 1'b0);
        step(1'b1, 1'b1, 1, -1, 1'b0);
        check_drained("mismatch", 1, c0);
        check_last("mismatch", 10, 5, 5);
        tests_run++;
        if (bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL mismatch_err_held: got err=%b, want 1", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int c0 = sv_count;
        win_dim = 4'd2;
        idle(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4, 4, i == 0);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.Sxx !== '0 || bus.Syy !== '0 || bus.Sxy !== '0 || bus.sum_val !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got Sxx=%0d Syy=%0d Sxy=%0d sum_val=%b err=%b, want all 0",
                     bus.Sxx, bus.Syy, bus.Sxy, bus.sum_val, bus.err);
        end
        bus.Ix_val = 1'b0;
        bus.Iy_val = 1'b0;
        bus.new_row = 1'b0;
        c0 = sv_count;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        idle(1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 3, -1, 1'b0);
        check_drained("reset_mid", 1, c0);
        check_last("reset_mid", 18, 2, -6);
    endtask

    task automatic test_back_to_back();
        int c0 = sv_count;
        win_dim = 4'd4;
        idle(1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256, i == 0);
        check_drained("back_to_back", 17, c0);
    endtask

    initial begin
        test_reset();
        test_uniform();
        test_sliding();
        test_row_restart();
        test_extremes();
        test_mismatch();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
